// File: rtl/hop_sprite.sv
// hop_sprite: grid-hop player sprite controller for the VGA game layer.
// Active-low direction buttons trigger fixed-distance hops. Each hop is animated
// over HOP_DIS/STEP animation ticks and is clamped to the display. A death request
// freezes the sprite for RESPAWN_FRAMES ticks, and the sprite then respawns at
// (IX, IY).
//
// Optional feature: define HOP_QUEUE_EN to add a one-entry hop queue. A press made
// during a hop is then replayed from the landing point.
//
// Ports:
//   i_clk      base clock
//   i_rst      synchronous active-high reset
//   i_ani_stb  animation strobe, one cycle per frame
//   i_animate  animation enable; low freezes all state
//   i_btn_n    active-low buttons {left, right, down, up}
//   i_dead     collision/death request (level)
//   o_x1/o_x2  left/right sprite edge (x -/+ H_WIDTH)
//   o_y1/o_y2  top/bottom sprite edge (y -/+ H_HEIGHT)
//   o_busy     high while not idle
//   o_dying    high while in the death sequence
//   o_dir      current/last hop direction: 0 up, 1 down, 2 right, 3 left
//   o_hops     completed up-hops, saturating at 255
module hop_sprite #(
    parameter int CW             = 12,
    parameter int H_WIDTH        = 11,
    parameter int H_HEIGHT       = 11,
    parameter int IX             = 320,
    parameter int IY             = 460,
    parameter int D_WIDTH        = 640,
    parameter int D_HEIGHT       = 480,
    parameter int HOP_DIS        = 48,
    parameter int STEP           = 4,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ani_stb,
    input  logic          i_animate,
    input  logic [3:0]    i_btn_n,
    input  logic          i_dead,
    output logic [CW-1:0] o_x1,
    output logic [CW-1:0] o_x2,
    output logic [CW-1:0] o_y1,
    output logic [CW-1:0] o_y2,
    output logic          o_busy,
    output logic          o_dying,
    output logic [1:0]    o_dir,
    output logic [7:0]    o_hops
);

    typedef enum logic [1:0] {IDLE, HOP, DEAD} state_t;

    localparam int STEPS   = HOP_DIS / STEP;
    localparam int CNT_MAX = (STEPS > RESPAWN_FRAMES) ? STEPS : RESPAWN_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Bounds are evaluated one bit wider than the coordinates. The up/left checks
    // are written as y >= HOP_DIS+H so that an underflow cannot wrap and pass.
    localparam logic [CW:0] V_MIN   = (CW+1)'(HOP_DIS + H_HEIGHT);
    localparam logic [CW:0] H_MIN   = (CW+1)'(HOP_DIS + H_WIDTH);
    localparam logic [CW:0] V_REACH = (CW+1)'(HOP_DIS + H_HEIGHT);
    localparam logic [CW:0] H_REACH = (CW+1)'(HOP_DIS + H_WIDTH);
    localparam logic [CW:0] V_LIMIT = (CW+1)'(D_HEIGHT - 1);
    localparam logic [CW:0] H_LIMIT = (CW+1)'(D_WIDTH - 1);

    state_t        state, state_nx;
    logic [CW-1:0] x, x_nx, y, y_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]    dir, dir_nx;
    logic [7:0]    hops, hops_nx;
    logic [3:0]    btn_prev_n, btn_prev_n_nx;
    logic          tick;
    logic [3:0]    press;
    logic          any_press;
    logic [1:0]    press_dir;
    logic [CW-1:0] mv_x, mv_y;
    logic [1:0]    mv_dir;
`ifdef HOP_QUEUE_EN
    logic          q_valid, q_valid_nx;
    logic [1:0]    q_dir, q_dir_nx;
`endif

    function automatic logic fits(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                  input logic [1:0] d);
        case (d)
            2'd0:    fits = {1'b0, py} >= V_MIN;
            2'd1:    fits = ({1'b0, py} + V_REACH) <= V_LIMIT;
            2'd2:    fits = ({1'b0, px} + H_REACH) <= H_LIMIT;
            default: fits = {1'b0, px} >= H_MIN;
        endcase
    endfunction

    assign tick  = i_ani_stb && i_animate;
    assign press = btn_prev_n & ~i_btn_n;
    assign any_press = |press;

    always_comb begin
        press_dir = 2'd3;
        if (press[0])      press_dir = 2'd0;
        else if (press[1]) press_dir = 2'd1;
        else if (press[2]) press_dir = 2'd2;
    end

    // One STEP from the current position. While idle the direction is that of
    // the new press; otherwise it is the latched hop direction.
    assign mv_dir = (state == IDLE) ? press_dir : dir;
    always_comb begin
        mv_x = x;
        mv_y = y;
        case (mv_dir)
            2'd0:    mv_y = y - CW'(STEP);
            2'd1:    mv_y = y + CW'(STEP);
            2'd2:    mv_x = x + CW'(STEP);
            default: mv_x = x - CW'(STEP);
        endcase
    end

    always_comb begin
        state_nx      = state;
        x_nx          = x;
        y_nx          = y;
        cnt_nx        = cnt;
        dir_nx        = dir;
        hops_nx       = hops;
        btn_prev_n_nx = btn_prev_n;
`ifdef HOP_QUEUE_EN
        q_valid_nx    = q_valid;
        q_dir_nx      = q_dir;
`endif
        if (tick) begin
            btn_prev_n_nx = i_btn_n;
            case (state)
                IDLE: begin
                    if (i_dead) begin
                        state_nx = DEAD;
                        cnt_nx   = '0;
                    end else if (any_press && fits(x, y, press_dir)) begin
                        state_nx = HOP;
                        dir_nx   = press_dir;
                        x_nx     = mv_x;
                        y_nx     = mv_y;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                HOP: begin
                    if (i_dead) begin
                        state_nx = DEAD;
                        cnt_nx   = '0;
`ifdef HOP_QUEUE_EN
                        q_valid_nx = 1'b0;
`endif
                    end else begin
                        x_nx = mv_x;
                        y_nx = mv_y;
                        if (cnt == CNT_W'(STEPS - 1)) begin
                            if (dir == 2'd0 && hops != '1)
                                hops_nx = hops + 8'd1;
                            state_nx = IDLE;
                            cnt_nx   = '0;
`ifdef HOP_QUEUE_EN
                            // The queued hop is checked from the landing point and
                            // takes its first step on the following tick.
                            if (q_valid && fits(mv_x, mv_y, q_dir)) begin
                                state_nx = HOP;
                                dir_nx   = q_dir;
                            end
                            q_valid_nx = 1'b0;
`endif
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
`ifdef HOP_QUEUE_EN
                            if (any_press) begin
                                q_valid_nx = 1'b1;
                                q_dir_nx   = press_dir;
                            end
`endif
                        end
                    end
                end
                default: begin
                    if (cnt == CNT_W'(RESPAWN_FRAMES - 1)) begin
                        state_nx = IDLE;
                        x_nx     = CW'(IX);
                        y_nx     = CW'(IY);
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            x          <= CW'(IX);
            y          <= CW'(IY);
            cnt        <= '0;
            dir        <= '0;
            hops       <= '0;
            btn_prev_n <= '1;
`ifdef HOP_QUEUE_EN
            q_valid    <= 1'b0;
            q_dir      <= '0;
`endif
        end else begin
            state      <= state_nx;
            x          <= x_nx;
            y          <= y_nx;
            cnt        <= cnt_nx;
            dir        <= dir_nx;
            hops       <= hops_nx;
            btn_prev_n <= btn_prev_n_nx;
`ifdef HOP_QUEUE_EN
            q_valid    <= q_valid_nx;
            q_dir      <= q_dir_nx;
`endif
        end
    end

    assign o_x1    = x - CW'(H_WIDTH);
    assign o_x2    = x + CW'(H_WIDTH);
    assign o_y1    = y - CW'(H_HEIGHT);
    assign o_y2    = y + CW'(H_HEIGHT);
    assign o_busy  = (state != IDLE);
    assign o_dying = (state == DEAD);
    assign o_dir   = dir;
    assign o_hops  = hops;

endmodule

// File: tb/tb_hop_sprite.sv
// tb_hop_sprite: scoreboard bench for hop_sprite with default parameters.
// The stimulus process drives one clock per step and queues the state expected
// after that edge. The monitor pops one expectation after every rising edge and
// compares it with the DUT outputs.
module tb_hop_sprite;

    localparam logic [3:0] REL  = 4'b1111;
    localparam logic [3:0] UP   = 4'b1110;
    localparam logic [3:0] DOWN = 4'b1101;
    localparam logic [3:0] RGT  = 4'b1011;
    localparam logic [3:0] UPLF = 4'b0110;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ani_stb = 1'b0;
    logic        i_animate = 1'b0;
    logic [3:0]  i_btn_n = 4'b1111;
    logic        i_dead = 1'b0;
    logic [11:0] o_x1, o_x2, o_y1, o_y2;
    logic        o_busy, o_dying;
    logic [1:0]  o_dir;
    logic [7:0]  o_hops;

    typedef struct {
        string nm;
        int    x;
        int    y;
        bit    busy;
        bit    dying;
        int    dir;
        int    hops;
    } exp_t;

    exp_t exp_q[$];
    int   assertions = 0;
    int   failures   = 0;

    hop_sprite dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ani_stb (i_ani_stb),
        .i_animate (i_animate),
        .i_btn_n   (i_btn_n),
        .i_dead    (i_dead),
        .o_x1      (o_x1),
        .o_x2      (o_x2),
        .o_y1      (o_y1),
        .o_y2      (o_y2),
        .o_busy    (o_busy),
        .o_dying   (o_dying),
        .o_dir     (o_dir),
        .o_hops    (o_hops)
    );

    always #5 i_clk = ~i_clk;

    // Monitor
    always @(posedge i_clk) begin
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            assertions++;
            if (int'(o_x1) != e.x - 11 || int'(o_x2) != e.x + 11 ||
                int'(o_y1) != e.y - 11 || int'(o_y2) != e.y + 11 ||
                o_busy != e.busy || o_dying != e.dying ||
                int'(o_dir) != e.dir || int'(o_hops) != e.hops) begin
                failures++;
                $display("FAIL %s: got x1=%0d x2=%0d y1=%0d y2=%0d busy=%0b dying=%0b dir=%0d hops=%0d; want x1=%0d x2=%0d y1=%0d y2=%0d busy=%0b dying=%0b dir=%0d hops=%0d",
                         e.nm, o_x1, o_x2, o_y1, o_y2, o_busy, o_dying, o_dir, o_hops,
                         e.x - 11, e.x + 11, e.y - 11, e.y + 11, e.busy, e.dying, e.dir, e.hops);
            end
        end
    end

    task automatic step(input logic rst, input logic stb, input logic anim,
                        input logic [3:0] btn, input logic dead, input string nm,
                        input int ex, input int ey, input bit eb, input bit ed,
                        input int edir, input int eh);
        exp_t e;
        @(negedge i_clk);
        i_rst     = rst;
        i_ani_stb = stb;
        i_animate = anim;
        i_btn_n   = btn;
        i_dead    = dead;
        e.nm = nm; e.x = ex; e.y = ey; e.busy = eb; e.dying = ed; e.dir = edir; e.hops = eh;
        exp_q.push_back(e);
        @(posedge i_clk);
    endtask

    task automatic tk(input logic [3:0] btn, input logic dead, input string nm,
                      input int ex, input int ey, input bit eb, input bit ed,
                      input int edir, input int eh);
        step(1'b0, 1'b1, 1'b1, btn, dead, nm, ex, ey, eb, ed, edir, eh);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, REL, 1'b0, "reset", 320, 460, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        do_reset();

        // Single up hop, then held button produces no further hop
        tk(UP, 1'b0, "up_first_step", 320, 456, 1'b1, 1'b0, 0, 0);
        for (int k = 2; k <= 11; k++)
            tk(UP, 1'b0, "up_hop", 320, 460 - 4 * k, 1'b1, 1'b0, 0, 0);
        tk(UP, 1'b0, "up_land", 320, 412, 1'b0, 1'b0, 0, 1);
        for (int i = 0; i < 28; i++)
            tk(UP, 1'b0, "hold_no_repeat", 320, 412, 1'b0, 1'b0, 0, 1);
        tk(REL, 1'b0, "release", 320, 412, 1'b0, 1'b0, 0, 1);

        // Up+left together: up wins. Reset mid-hop clears everything
        tk(UPLF, 1'b0, "up_beats_left", 320, 408, 1'b1, 1'b0, 0, 1);
        tk(UPLF, 1'b0, "up_beats_left2", 320, 404, 1'b1, 1'b0, 0, 1);
        step(1'b1, 1'b1, 1'b1, UPLF, 1'b0, "rst_midhop", 320, 460, 1'b0, 1'b0, 0, 0);
        tk(REL, 1'b0, "after_rst", 320, 460, 1'b0, 1'b0, 0, 0);

        // Repeated up hops up to the top boundary, with freeze checks
        for (int h = 1; h <= 9; h++) begin
            int y0;
            y0 = 460 - 48 * (h - 1);
            for (int k = 1; k <= 11; k++) begin
                tk((k == 1) ? UP : REL, 1'b0, "climb", 320, y0 - 4 * k, 1'b1, 1'b0, 0, h - 1);
                if (h == 1 && k == 4) begin
                    step(1'b0, 1'b1, 1'b0, REL, 1'b0, "anim_low_freeze", 320, y0 - 16, 1'b1, 1'b0, 0, 0);
                    step(1'b0, 1'b0, 1'b1, REL, 1'b0, "no_stb_freeze", 320, y0 - 16, 1'b1, 1'b0, 0, 0);
                end
            end
            tk(REL, 1'b0, "climb_land", 320, y0 - 48, 1'b0, 1'b0, 0, h);
        end
        tk(UP, 1'b0, "up_reject_top", 320, 28, 1'b0, 1'b0, 0, 9);
        tk(REL, 1'b0, "up_reject_top2", 320, 28, 1'b0, 1'b0, 0, 9);

        // Down from spawn is rejected
        do_reset();
        tk(DOWN, 1'b0, "down_reject", 320, 460, 1'b0, 1'b0, 0, 0);
        tk(REL, 1'b0, "down_reject2", 320, 460, 1'b0, 1'b0, 0, 0);

        // Death during a hop, then respawn
        tk(UP, 1'b0, "pre_death", 320, 456, 1'b1, 1'b0, 0, 0);
        for (int k = 2; k <= 6; k++)
            tk(REL, 1'b0, "pre_death", 320, 460 - 4 * k, 1'b1, 1'b0, 0, 0);
        tk(REL, 1'b1, "dead_entry", 320, 436, 1'b1, 1'b1, 0, 0);
        for (int i = 1; i <= 59; i++)
            tk((i == 5) ? UP : REL, (i < 10), "dying", 320, 436, 1'b1, 1'b1, 0, 0);
        tk(REL, 1'b0, "respawn", 320, 460, 1'b0, 1'b0, 0, 0);
        tk(REL, 1'b0, "respawn_idle", 320, 460, 1'b0, 1'b0, 0, 0);

        // Press right during an up hop
        do_reset();
        tk(UP, 1'b0, "q_up", 320, 456, 1'b1, 1'b0, 0, 0);
        tk(REL, 1'b0, "q_up", 320, 452, 1'b1, 1'b0, 0, 0);
        tk(RGT, 1'b0, "q_right_press", 320, 448, 1'b1, 1'b0, 0, 0);
        for (int k = 4; k <= 11; k++)
            tk(REL, 1'b0, "q_up", 320, 460 - 4 * k, 1'b1, 1'b0, 0, 0);
`ifdef HOP_QUEUE_EN
        tk(REL, 1'b0, "q_land_chain", 320, 412, 1'b1, 1'b0, 2, 1);
        for (int j = 1; j <= 12; j++)
            tk(REL, 1'b0, "q_right_hop", 320 + 4 * j, 412, (j < 12), 1'b0, 2, 1);
`else
        tk(REL, 1'b0, "q_land_plain", 320, 412, 1'b0, 1'b0, 0, 1);
        for (int j = 1; j <= 12; j++)
            tk(REL, 1'b0, "no_queue", 320, 412, 1'b0, 1'b0, 0, 1);
`endif

        @(negedge i_clk);
        @(negedge i_clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
